// File: rtl/gcc_peak_search.sv
// -----------------------------------------------------------------------------
// gcc_peak_search
//
// Purpose:
//   Watches the GCC-PHAT cross-correlation stream, one frame of FRAME_LEN lag
//   bins per TDOA estimate. It tracks the largest bin and reports that bin's
//   index, value and signed circular lag. Each report comes with a one-cycle
//   result pulse and a sticky interrupt for the PS, so the PS no longer has to
//   scan BRAM to find the peak.
//
// Ports:
//   clk_240M                in   single clock; all logic on the rising edge
//   rstn                    in   synchronous active-low reset
//   GCC_PHAT_m_axis_tvalid  in   sample valid
//   GCC_PHAT_m_axis_tdata   in   correlation sample, signed, DATA_W bits
//   GCC_PHAT_m_axis_tlast   in   last bin of the frame
//   GCC_PHAT_m_axis_tready  out  1 whenever out of reset (the block never stalls)
//   peak_valid              out  one-cycle pulse; result outputs updated
//   peak_index              out  bin index of the maximum
//   peak_lag                out  signed circular lag of the maximum
//   peak_value              out  maximum sample value
//   frame_err               out  one-cycle pulse; malformed frame dropped
//   peak_irq                out  sticky; set with peak_valid, cleared by peak_ack
//   peak_ack                in   PS acknowledge for peak_irq
//
// Handshake: a beat transfers on any rising edge where tvalid && tready.
// tready is simply rstn, so every beat is taken as soon as reset is released.
//
// Build option:
//   PEAK_LAG_LIMIT_EN  When defined, only bins with |lag| <= MAX_LAG compete
//                      for the maximum. All bins still count toward framing.
//                      MAX_LAG must be less than FRAME_LEN/2.
// -----------------------------------------------------------------------------
module gcc_peak_search #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 1024,
   parameter int IDX_W     = 10,
   parameter int MAX_LAG   = 64
) (
   input  logic              clk_240M,
   input  logic              rstn,
   input  logic              GCC_PHAT_m_axis_tvalid,
   input  logic [DATA_W-1:0] GCC_PHAT_m_axis_tdata,
   input  logic              GCC_PHAT_m_axis_tlast,
   output logic              GCC_PHAT_m_axis_tready,
   output logic              peak_valid,
   output logic [IDX_W-1:0]  peak_index,
   output logic [IDX_W-1:0]  peak_lag,
   output logic [DATA_W-1:0] peak_value,
   output logic              frame_err,
   output logic              peak_irq,
   input  logic              peak_ack
);

   typedef enum logic {
      ST_SCAN   = 1'b0,
      ST_REPORT = 1'b1
   } state_t;

`ifdef PEAK_LAG_LIMIT_EN
   localparam logic LAG_LIMIT = 1'b1;
`else
   localparam logic LAG_LIMIT = 1'b0;
`endif

   localparam logic [IDX_W-1:0] LAST_BIN  = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] POS_LIMIT = IDX_W'(MAX_LAG);
   // Bins at or above this index map to lags in -MAX_LAG..-1.
   localparam logic [IDX_W-1:0] NEG_LIMIT = IDX_W'(FRAME_LEN - MAX_LAG);

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          cnt_q, cnt_d;
   logic signed [DATA_W-1:0]  max_q, max_d;
   logic [IDX_W-1:0]          max_idx_q, max_idx_d;
   logic [IDX_W-1:0]          peak_index_q, peak_index_d;
   logic [DATA_W-1:0]         peak_value_q, peak_value_d;
   logic                      frame_err_q, frame_err_d;
   logic                      peak_irq_q, peak_irq_d;

   logic                      beat;
   logic                      window_hit;
   logic                      in_window;
   logic                      take;
   logic                      good_frame;
   logic signed [DATA_W-1:0]  sample;
   logic signed [DATA_W-1:0]  cand_val;
   logic [IDX_W-1:0]          cand_idx;

   assign GCC_PHAT_m_axis_tready = rstn;
   assign beat   = GCC_PHAT_m_axis_tvalid & rstn;
   assign sample = $signed(GCC_PHAT_m_axis_tdata);

   // Circular lag window. Positive lags are the low bins. Negative lags are
   // the high bins. The NEG_LIMIT term is skipped when MAX_LAG is 0, because
   // FRAME_LEN - 0 would wrap to index 0.
   assign window_hit = (cnt_q <= POS_LIMIT) ||
                       ((MAX_LAG > 0) && (cnt_q >= NEG_LIMIT));
   assign in_window  = !LAG_LIMIT || window_hit;

   // Bin 0 always reloads the tracker, so nothing from the previous frame
   // carries over. Later bins replace the maximum only when strictly larger,
   // which means the earliest bin wins a tie.
   assign take     = (cnt_q == '0) || (in_window && (sample > max_q));
   assign cand_val = take ? sample : max_q;
   assign cand_idx = take ? cnt_q  : max_idx_q;

   always_comb begin
      state_d      = ST_SCAN;
      cnt_d        = cnt_q;
      max_d        = max_q;
      max_idx_d    = max_idx_q;
      peak_index_d = peak_index_q;
      peak_value_d = peak_value_q;
      frame_err_d  = 1'b0;
      good_frame   = 1'b0;

      // REPORT lasts exactly one cycle. A beat that arrives during REPORT
      // belongs to the next frame and is handled like any other beat.
      if (beat) begin
         max_d     = cand_val;
         max_idx_d = cand_idx;
         if (GCC_PHAT_m_axis_tlast) begin
            cnt_d = '0;
            if (cnt_q == LAST_BIN) begin
               good_frame   = 1'b1;
               state_d      = ST_REPORT;
               peak_index_d = cand_idx;
               peak_value_d = cand_val;
            end else begin
               frame_err_d = 1'b1;
            end
         end else if (cnt_q == LAST_BIN) begin
            // A full frame arrived without tlast: drop it and start over.
            cnt_d       = '0;
            frame_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + IDX_W'(1);
         end
      end

      // The set terms cover both the edge that enters REPORT and the REPORT
      // cycle itself. An ack that arrives while peak_valid is high therefore
      // does not clear the interrupt; the ack has to come afterwards.
      peak_irq_d = good_frame | (state_q == ST_REPORT) | (peak_irq_q & ~peak_ack);
   end

   always_ff @(posedge clk_240M) begin
      if (!rstn) begin
         state_q      <= ST_SCAN;
         cnt_q        <= '0;
         max_q        <= '0;
         max_idx_q    <= '0;
         peak_index_q <= '0;
         peak_value_q <= '0;
         frame_err_q  <= 1'b0;
         peak_irq_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         max_q        <= max_d;
         max_idx_q    <= max_idx_d;
         peak_index_q <= peak_index_d;
         peak_value_q <= peak_value_d;
         frame_err_q  <= frame_err_d;
         peak_irq_q   <= peak_irq_d;
      end
   end

   assign peak_valid = (state_q == ST_REPORT);
   assign peak_index = peak_index_q;
   // For index >= FRAME_LEN/2, index - FRAME_LEN taken modulo 2**IDX_W is the
   // same bit pattern as the index. Read as IDX_W-bit two's complement, the
   // index register already holds the signed lag.
   assign peak_lag   = peak_index_q;
   assign peak_value = peak_value_q;
   assign frame_err  = frame_err_q;
   assign peak_irq   = peak_irq_q;

endmodule
